// File: rtl/key_sw_input_port_pkg.sv
// Shared constants for the KEY/SW input port.
//   - Default I/O addresses of the four registers (data and ctrl/status, per device).
//   - Bit positions inside a ctrl/status register.
//   - Register-select encoding used by the address decode.
//   - ctrlWord(): packs the status bits into a full ctrl register value.
package key_sw_input_port_pkg;

    localparam logic [31:0] ADDR_KEY_DEF   = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW_DEF    = 32'hF000_0014;
    localparam logic [31:0] ADDR_KCTRL_DEF = 32'hF000_0110;
    localparam logic [31:0] ADDR_SCTRL_DEF = 32'hF000_0114;

    localparam int unsigned CTRL_READY   = 0;
    localparam int unsigned CTRL_OVERRUN = 2;
    localparam int unsigned CTRL_IE      = 8;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_KEY,
        SEL_SW,
        SEL_KCTRL,
        SEL_SCTRL
    } regSel_t;

    function automatic logic [31:0] ctrlWord(input logic ready,
                                             input logic overrun,
                                             input logic ie);
        logic [31:0] w;
        w               = '0;
        w[CTRL_READY]   = ready;
        w[CTRL_OVERRUN] = overrun;
        w[CTRL_IE]      = ie;
        return w;
    endfunction

endpackage

// File: rtl/key_sw_input_port_debouncer.sv
// input_debouncer: two-flop synchronizer followed by a per-bit debounce counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   pins         : raw asynchronous inputs (already polarity-corrected by the caller)
//   stable       : debounced level per bit
//   change       : one-cycle pulse per bit, high in the cycle whose clock edge updates stable
// A new level is accepted after it has been seen on the synchronized input for
// DEBOUNCE_CYCLES consecutive clock edges; any return to the stable level restarts the count.
module input_debouncer #(
    parameter int unsigned WIDTH           = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] change
);

    localparam int unsigned CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CW-1:0]    cnt [WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    // Combinational so the status logic can react on the same edge that updates stable.
    always_comb begin
        change = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            change[i] = (sync2[i] != stable[i]) && (cnt[i] == CMAX);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CMAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/key_sw_input_port.sv
// key_sw_input_port: memory-mapped, debounced KEY/SW input stage.
//   clk, reset_n : clock, asynchronous active-low reset
//   KEY          : raw pushbuttons, 0 = pressed
//   SW           : raw slide switches
//   addr         : I/O address
//   rdEn, wrEn   : load / store in progress this cycle
//   wrData       : store data
//   rdData       : selected register (combinational), 0 when no hit
//   hit          : addr matches one of the four registers
//   irq          : (KCTRL.ready & KCTRL.ie) | (SCTRL.ready & SCTRL.ie)
// Ctrl/status registers: [0] ready (RO), [2] overrun (write 0 clears), [8] ie (RW).
module key_sw_input_port
    import key_sw_input_port_pkg::*;
#(
    parameter int unsigned       DBITS           = 32,
    parameter int unsigned       KEY_BITS        = 4,
    parameter int unsigned       SW_BITS         = 10,
    parameter int unsigned       DEBOUNCE_CYCLES = 500000,
    parameter logic [DBITS-1:0]  ADDR_KEY        = DBITS'(ADDR_KEY_DEF),
    parameter logic [DBITS-1:0]  ADDR_SW         = DBITS'(ADDR_SW_DEF),
    parameter logic [DBITS-1:0]  ADDR_KCTRL      = DBITS'(ADDR_KCTRL_DEF),
    parameter logic [DBITS-1:0]  ADDR_SCTRL      = DBITS'(ADDR_SCTRL_DEF)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [KEY_BITS-1:0] KEY,
    input  logic [SW_BITS-1:0]  SW,
    input  logic [DBITS-1:0]    addr,
    input  logic                rdEn,
    input  logic                wrEn,
    input  logic [DBITS-1:0]    wrData,
    output logic [DBITS-1:0]    rdData,
    output logic                hit,
    output logic                irq
);

    logic [KEY_BITS-1:0] keyStable;
    logic [KEY_BITS-1:0] keyChange;
    logic [SW_BITS-1:0]  swStable;
    logic [SW_BITS-1:0]  swChange;

    logic keyReady, keyOverrun, keyIe;
    logic swReady,  swOverrun,  swIe;

    regSel_t sel;
    logic    keyEvent, swEvent;
    logic    keyRead,  swRead;
    logic    kctrlWr,  sctrlWr;

    // Only bits [2] and [8] of a store are meaningful.
    logic unusedWrData;
    assign unusedWrData = ^wrData;

    // KEY is inverted so that 1 = pressed from here on.
    input_debouncer #(
        .WIDTH           (KEY_BITS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) keyDebounce (
        .clk     (clk),
        .reset_n (reset_n),
        .pins    (~KEY),
        .stable  (keyStable),
        .change  (keyChange)
    );

    input_debouncer #(
        .WIDTH           (SW_BITS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) swDebounce (
        .clk     (clk),
        .reset_n (reset_n),
        .pins    (SW),
        .stable  (swStable),
        .change  (swChange)
    );

    always_comb begin
        sel = SEL_NONE;
        if      (addr == ADDR_KEY)   sel = SEL_KEY;
        else if (addr == ADDR_SW)    sel = SEL_SW;
        else if (addr == ADDR_KCTRL) sel = SEL_KCTRL;
        else if (addr == ADDR_SCTRL) sel = SEL_SCTRL;
    end

    assign hit      = (sel != SEL_NONE);
    assign keyEvent = |keyChange;
    assign swEvent  = |swChange;
    assign keyRead  = rdEn && (sel == SEL_KEY);
    assign swRead   = rdEn && (sel == SEL_SW);
    assign kctrlWr  = wrEn && (sel == SEL_KCTRL);
    assign sctrlWr  = wrEn && (sel == SEL_SCTRL);

    always_comb begin
        rdData = '0;
        case (sel)
            SEL_KEY:   rdData = DBITS'(keyStable);
            SEL_SW:    rdData = DBITS'(swStable);
            SEL_KCTRL: rdData = DBITS'(ctrlWord(keyReady, keyOverrun, keyIe));
            SEL_SCTRL: rdData = DBITS'(ctrlWord(swReady, swOverrun, swIe));
            default:   rdData = '0;
        endcase
    end

    assign irq = (keyReady & keyIe) | (swReady & swIe);

    // Priority per device: a new event beats a data read (ready stays set) and
    // beats a software clear of overrun. Overrun is only flagged when the
    // previous event was still unread and is not being read this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keyReady   <= 1'b0;
            keyOverrun <= 1'b0;
            keyIe      <= 1'b0;
            swReady    <= 1'b0;
            swOverrun  <= 1'b0;
            swIe       <= 1'b0;
        end else begin
            if (keyEvent)     keyReady <= 1'b1;
            else if (keyRead) keyReady <= 1'b0;

            if (keyEvent && keyReady && !keyRead)        keyOverrun <= 1'b1;
            else if (kctrlWr && !wrData[CTRL_OVERRUN])   keyOverrun <= 1'b0;

            if (kctrlWr) keyIe <= wrData[CTRL_IE];

            if (swEvent)     swReady <= 1'b1;
            else if (swRead) swReady <= 1'b0;

            if (swEvent && swReady && !swRead)           swOverrun <= 1'b1;
            else if (sctrlWr && !wrData[CTRL_OVERRUN])   swOverrun <= 1'b0;

            if (sctrlWr) swIe <= wrData[CTRL_IE];
        end
    end

endmodule
